dmem_responder: RTL and testbench

Data-memory responder for the ARM core's load/store port. It sits between the processor's data-side request path and a word-addressed RAM array. It accepts one load or store request through a valid/ready handshake, inserts a fixed number of wait states, performs the access, and returns read data and an error flag through a second valid/ready handshake. It is the slave end of the data bus that the processor drives, and it replaces the zero-latency combinational data memory with a realistic multi-cycle responder.

---
 rtl/dmem_responder.sv | 158 +++++++++++++++
 tb/tb_dmem_responder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory slave for the core's load/store port.
// One request is accepted through a valid/ready handshake, WAIT_CYCLES wait
// states are inserted, the word-addressed array is accessed, and the result
// is returned through a second valid/ready handshake.
// Optional feature macro: DMEM_BYTE_STROBE_EN enables per-byte-lane stores
// under req_strb. When it is undefined, every legal store writes the whole word.
module dmem_responder #(
   parameter int unsigned DEPTH       = 64,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_strb,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy
);

   localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACCESS,
      S_RESP
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        strb_q, strb_d;
   logic              we_q, we_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;

   logic [31:0]       mem_q [DEPTH];

   logic [29:0]       word_addr;
   logic [AW-1:0]     widx;
   logic              acc_err;
   logic              mem_wr;

   // Address decode for the latched request.
   assign word_addr = addr_q[31:2];
   assign widx      = addr_q[AW+1:2];
   assign acc_err   = (addr_q[1:0] != 2'b00) || ({2'b00, word_addr} >= DEPTH);
   assign mem_wr    = (state_q == S_ACCESS) && we_q && !acc_err;

   assign req_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign rsp_valid = (state_q == S_RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

`ifndef DMEM_BYTE_STROBE_EN
   logic strb_unused;
   assign strb_unused = ^strb_q;
`endif

   // State, counter, request latch and response registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         strb_q  <= '0;
         we_q    <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         strb_q  <= strb_d;
         we_q    <= we_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic: accept, count wait states, access, then hold the response.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      strb_d  = strb_q;
      we_d    = we_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               addr_d  = req_addr;
               wdata_d = req_wdata;
               strb_d  = req_strb;
               we_d    = req_we;
               if (WAIT_CYCLES == 0) begin
                  state_d = S_ACCESS;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = CNT_LOAD;
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q <= CNT_ONE) begin
               state_d = S_ACCESS;
            end
         end
         S_ACCESS: begin
            state_d = S_RESP;
            err_d   = acc_err;
            rdata_d = (!we_q && !acc_err) ? mem_q[widx] : '0;
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
               rdata_d = '0;
               err_d   = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Array write on the ACCESS exit edge; the array itself is never reset.
   always_ff @(posedge clk) begin
      if (mem_wr) begin
`ifdef DMEM_BYTE_STROBE_EN
         for (int unsigned i = 0; i < 4; i++) begin
            if (strb_q[i]) begin
               mem_q[widx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
         end
`else
         mem_q[widx] <= wdata_q;
`endif
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: a default-parameter
// instance for functional checks plus WAIT_CYCLES=0 and =5 instances for
// latency checks.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_strb = '0;
   logic        rsp_ready = 1'b1;
   logic        req_ready, rsp_valid, rsp_err, busy;
   logic [31:0] rsp_rdata;

   logic        t_req_valid = 1'b0;
   logic        w0_req_ready, w0_rsp_valid, w0_rsp_err, w0_busy;
   logic [31:0] w0_rsp_rdata;
   logic        w5_req_ready, w5_rsp_valid, w5_rsp_err, w5_busy;
   logic [31:0] w5_rsp_rdata;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) u_dut (
      .clk(clk), .reset(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .busy(busy)
   );

   dmem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) u_w0 (
      .clk(clk), .reset(rst_n),
      .req_valid(t_req_valid), .req_ready(w0_req_ready), .req_we(1'b0),
      .req_addr(32'h0), .req_wdata(32'h0), .req_strb(4'hF),
      .rsp_valid(w0_rsp_valid), .rsp_ready(1'b1), .rsp_rdata(w0_rsp_rdata),
      .rsp_err(w0_rsp_err), .busy(w0_busy)
   );

   dmem_responder #(.DEPTH(64), .WAIT_CYCLES(5)) u_w5 (
      .clk(clk), .reset(rst_n),
      .req_valid(t_req_valid), .req_ready(w5_req_ready), .req_we(1'b0),
      .req_addr(32'h0), .req_wdata(32'h0), .req_strb(4'hF),
      .rsp_valid(w5_rsp_valid), .rsp_ready(1'b1), .rsp_rdata(w5_rsp_rdata),
      .rsp_err(w5_rsp_err), .busy(w5_busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One transaction on the main instance with rsp_ready high; entered 1ns
   // after a rising edge with the DUT idle, returns 1ns after the handshake edge.
   task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, output logic [31:0] rdata, output logic err,
                      output int lat);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_strb  = strb;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 0;
      while (rsp_valid !== 1'b1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      rdata = rsp_rdata;
      err   = rsp_err;
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;
      int          v0, r0, v5, r5;

      // Reset state
      #12;
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_rsp_err",   32'(rsp_err), 32'd0);
      check("rst_busy",      32'(busy), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Store then load 0x10
      txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
      check("st10_lat",   32'(lat), 32'd3);
      check("st10_err",   32'(er), 32'd0);
      check("st10_rdata", rd, 32'd0);
      check("st10_ready_after", 32'(req_ready), 32'd1);
      check("st10_valid_after", 32'(rsp_valid), 32'd0);
      txn(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
      check("ld10_lat",   32'(lat), 32'd3);
      check("ld10_err",   32'(er), 32'd0);
      check("ld10_rdata", rd, 32'hDEADBEEF);

      // Errors: misaligned load, out-of-range store and load; word 0 untouched
      txn(1'b1, 32'h00, 32'h0BADF00D, 4'hF, rd, er, lat);
      check("st00_err", 32'(er), 32'd0);
      txn(1'b0, 32'h12, 32'h0, 4'hF, rd, er, lat);
      check("mis_err",   32'(er), 32'd1);
      check("mis_rdata", rd, 32'd0);
      txn(1'b1, 32'h100, 32'hCAFEF00D, 4'hF, rd, er, lat);
      check("oor_st_err",   32'(er), 32'd1);
      check("oor_st_rdata", rd, 32'd0);
      txn(1'b0, 32'h100, 32'h0, 4'hF, rd, er, lat);
      check("oor_ld_err",   32'(er), 32'd1);
      check("oor_ld_rdata", rd, 32'd0);
      txn(1'b0, 32'h00, 32'h0, 4'hF, rd, er, lat);
      check("ld00_rdata", rd, 32'h0BADF00D);
      check("ld00_err",   32'(er), 32'd0);

      // Backpressure on a load of 0x10 with a competing request offered
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      check("bp_valid_rise", 32'(rsp_valid), 32'd1);
      check("bp_rdata_rise", rsp_rdata, 32'hDEADBEEF);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h11111111; req_strb = 4'hF;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("bp_valid_hold", 32'(rsp_valid), 32'd1);
         check("bp_rdata_hold", rsp_rdata, 32'hDEADBEEF);
         check("bp_err_hold",   32'(rsp_err), 32'd0);
         check("bp_ready_low",  32'(req_ready), 32'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_valid_done", 32'(rsp_valid), 32'd0);
      check("bp_busy_done",  32'(busy), 32'd0);
      txn(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
      check("bp_not_taken", rd, 32'hDEADBEEF);

      // Reset during WAIT of a store to 0x20
      txn(1'b1, 32'h20, 32'h01234567, 4'hF, rd, er, lat);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h5555AAAA; req_strb = 4'hF;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("ar_busy_wait", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("ar_req_ready", 32'(req_ready), 32'd1);
      check("ar_rsp_valid", 32'(rsp_valid), 32'd0);
      check("ar_rsp_rdata", rsp_rdata, 32'd0);
      check("ar_rsp_err",   32'(rsp_err), 32'd0);
      check("ar_busy",      32'(busy), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      txn(1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat);
      check("ar_not_committed", rd, 32'h01234567);

      // Byte strobes
      txn(1'b1, 32'h30, 32'hFFFFFFFF, 4'hF, rd, er, lat);
      txn(1'b1, 32'h30, 32'h12345678, 4'b0101, rd, er, lat);
      check("strb_st_err", 32'(er), 32'd0);
      txn(1'b0, 32'h30, 32'h0, 4'hF, rd, er, lat);
`ifdef DMEM_BYTE_STROBE_EN
      check("strb_rdata", rd, 32'hFF34FF78);
      txn(1'b1, 32'h30, 32'hAAAAAAAA, 4'b0000, rd, er, lat);
      check("strb0_err", 32'(er), 32'd0);
      txn(1'b0, 32'h30, 32'h0, 4'hF, rd, er, lat);
      check("strb0_rdata", rd, 32'hFF34FF78);
`else
      check("strb_rdata", rd, 32'h12345678);
`endif

      // Latency of WAIT_CYCLES=0 and WAIT_CYCLES=5 instances
      v0 = 0; r0 = 0; v5 = 0; r5 = 0;
      t_req_valid = 1'b1;
      @(posedge clk); #1;
      t_req_valid = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         if (w0_rsp_valid === 1'b1 && v0 == 0) v0 = k;
         if (w0_req_ready === 1'b1 && v0 != 0 && r0 == 0) r0 = k;
         if (w5_rsp_valid === 1'b1 && v5 == 0) v5 = k;
         if (w5_req_ready === 1'b1 && v5 != 0 && r5 == 0) r5 = k;
      end
      check("w0_valid_edge", 32'(v0), 32'd1);
      check("w0_ready_edge", 32'(r0), 32'd2);
      check("w5_valid_edge", 32'(v5), 32'd6);
      check("w5_ready_edge", 32'(r5), 32'd7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
